// File: rtl/ps2_key_serializer.sv
// Re-serialises hps_io key events into a device->host PS/2 stream (ps2_clk/ps2_data).
// Each event is queued, then expanded to E0 / F0 prefix frames plus the scancode frame.
module ps2_key_serializer #(
    parameter int HALF_PERIOD = 1145,
    parameter int GAP_CYCLES  = 2290,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    output logic        ps2_clk,
    output logic        ps2_data,
    output logic        busy,
    output logic        overflow
);

    localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int HW = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
    localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_POP  = 3'd1;
    localparam logic [2:0] ST_HIGH = 3'd2;
    localparam logic [2:0] ST_LOW  = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    logic [2:0]    state;
    logic          tog_q;
    logic          armed_q;
    logic          key_event;
    logic [9:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   fifo_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          do_push;
    logic          do_pop;
    logic [9:0]    head;
    logic [7:0]    list_next [3];
    logic [1:0]    last_next;
    logic [7:0]    byte_list [3];
    logic [1:0]    byte_idx;
    logic [1:0]    last_idx;
    logic [3:0]    bit_cnt;
    logic [HW-1:0] half_cnt;
    logic [GW-1:0] gap_cnt;

    // 11-bit frame, index 0 = start bit; parity is odd over the data byte.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
        logic [10:0] f;
        f = {1'b1, ~^b, b, 1'b0};
        return f[idx];
    endfunction

    // The first cycle after reset only captures the toggle level, so a held-high strobe is not an event.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            tog_q   <= ps2_key[10];
            armed_q <= 1'b1;
        end
    end

    assign key_event  = armed_q && (ps2_key[10] != tog_q);
    assign fifo_full  = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign do_push    = key_event && !fifo_full;
    assign do_pop     = (state == ST_POP);
    assign head       = fifo_mem[rd_ptr];
    assign busy       = (state != ST_IDLE) || !fifo_empty;

    always_ff @(posedge clk_sys) begin
        if (do_push) fifo_mem[wr_ptr] <= ps2_key[9:0];
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= key_event && fifo_full;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Byte list for the event at the FIFO head: [E0] [F0] scancode.
    always_comb begin
        list_next[0] = head[7:0];
        list_next[1] = 8'h00;
        list_next[2] = 8'h00;
        last_next    = 2'd0;
        if (head[8] && !head[9]) begin
            list_next[0] = 8'hE0;
            list_next[1] = 8'hF0;
            list_next[2] = head[7:0];
            last_next    = 2'd2;
        end else if (head[8] || !head[9]) begin
            list_next[0] = head[8] ? 8'hE0 : 8'hF0;
            list_next[1] = head[7:0];
            last_next    = 2'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            ps2_clk      <= 1'b1;
            ps2_data     <= 1'b1;
            byte_list[0] <= 8'h00;
            byte_list[1] <= 8'h00;
            byte_list[2] <= 8'h00;
            byte_idx     <= 2'd0;
            last_idx     <= 2'd0;
            bit_cnt      <= 4'd0;
            half_cnt     <= '0;
            gap_cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) state <= ST_POP;
                end
                ST_POP: begin
                    byte_list <= list_next;
                    last_idx  <= last_next;
                    byte_idx  <= 2'd0;
                    bit_cnt   <= 4'd0;
                    half_cnt  <= '0;
                    ps2_data  <= 1'b0;
                    state     <= ST_HIGH;
                end
                ST_HIGH: begin
                    if (half_cnt == HW'(HALF_PERIOD - 1)) begin
                        half_cnt <= '0;
                        ps2_clk  <= 1'b0;
                        state    <= ST_LOW;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                ST_LOW: begin
                    if (half_cnt == HW'(HALF_PERIOD - 1)) begin
                        half_cnt <= '0;
                        ps2_clk  <= 1'b1;
                        if (bit_cnt == 4'd10) begin
                            ps2_data <= 1'b1;
                            gap_cnt  <= '0;
                            state    <= ST_GAP;
                        end else begin
                            bit_cnt  <= bit_cnt + 4'd1;
                            ps2_data <= frame_bit(byte_list[byte_idx], bit_cnt + 4'd1);
                            state    <= ST_HIGH;
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        if (byte_idx != last_idx) begin
                            byte_idx <= byte_idx + 2'd1;
                            bit_cnt  <= 4'd0;
                            ps2_data <= 1'b0;
                            state    <= ST_HIGH;
                        end else if (!fifo_empty) begin
                            state <= ST_POP;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
